// File: rtl/decoder_scan_sequencer_if.sv
// Handshake/bus bundle between a scan controller and decoder_scan_sequencer.
// The sequencer sits on the slave side; whoever commands it uses the master side.
interface decoder_scan_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              continuous;
    logic              stop;
    logic [ADDR_W-1:0] A;
    logic              EN;
    logic              busy;
    logic              line_done;
    logic              frame_done;

    modport master (
        output start, continuous, stop,
        input  A, EN, busy, line_done, frame_done
    );

    modport slave (
        input  start, continuous, stop,
        output A, EN, busy, line_done, frame_done
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Walks a decoder select through NUM_LINES lines, holding EN for DWELL cycles per line
// with GAP blanking cycles between lines; single-frame or continuous, with graceful stop.
module decoder_scan_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int NUM_LINES = 16,
    parameter int DWELL     = 8,
    parameter int GAP       = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    decoder_scan_sequencer_if.slave  bus
);
    localparam int MAX_CNT = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              stop_pending_q, stop_pending_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] a_next;

    assign a_next = (a_q == LAST_A) ? '0 : a_q + ADDR_W'(1);

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        stop_pending_d = stop_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d        = ST_DRIVE;
                    a_d            = '0;
                    cnt_d          = '0;
                    mode_d         = bus.continuous;
                    stop_pending_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (bus.stop) begin
                    stop_pending_d = 1'b1;
                end
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    // A stop only takes effect once the current line has had its full dwell.
                    if (stop_pending_q || bus.stop || (a_q == LAST_A && !mode_q)) begin
                        state_d        = ST_IDLE;
                        a_d            = '0;
                        stop_pending_d = 1'b0;
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        a_d = a_next;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (bus.stop) begin
                    stop_pending_d = 1'b1;
                end
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (stop_pending_q || bus.stop) begin
                        state_d        = ST_IDLE;
                        a_d            = '0;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = ST_DRIVE;
                        a_d     = a_next;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                a_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops aligned with the state.
    always_comb begin
        en_d         = (state_d == ST_DRIVE);
        busy_d       = (state_d != ST_IDLE);
        line_done_d  = en_d && (cnt_d == DWELL_LAST);
        frame_done_d = line_done_d && (a_d == LAST_A);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            a_q            <= '0;
            cnt_q          <= '0;
            mode_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            en_q           <= 1'b0;
            busy_q         <= 1'b0;
            line_done_q    <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            stop_pending_q <= stop_pending_d;
            en_q           <= en_d;
            busy_q         <= busy_d;
            line_done_q    <= line_done_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.A          = a_q;
    assign bus.EN         = en_q;
    assign bus.busy       = busy_q;
    assign bus.line_done  = line_done_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: default scan (DWELL=8, GAP=1) plus a
// DWELL=1/GAP=0 instance, checked cycle by cycle against a timing model.
module tb_decoder_scan_sequencer;
    typedef struct packed {
        logic [3:0] a;
        logic       en;
        logic       busy;
        logic       ld;
        logic       fd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   ld_cnt;
    int   fd_cnt;
    int   busy_cnt;
    int   waited;

    decoder_scan_sequencer_if #(.ADDR_W(4)) if1 ();
    decoder_scan_sequencer_if #(.ADDR_W(4)) if2 ();

    decoder_scan_sequencer #(.ADDR_W(4), .NUM_LINES(16), .DWELL(8), .GAP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    decoder_scan_sequencer #(.ADDR_W(4), .NUM_LINES(16), .DWELL(1), .GAP(0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for the default instance, c = cycles since the accepted start.
    function automatic exp_t model_frame(int c, bit cont);
        exp_t e;
        int   k;
        int   off;
        e = '0;
        if (c < 1 || (!cont && c > 143)) return e;
        k      = (c - 1) / 9;
        off    = (c - 1) % 9;
        e.busy = 1'b1;
        e.a    = 4'(k % 16);
        e.en   = (off < 8);
        e.ld   = (off == 7);
        e.fd   = e.ld && ((k % 16) == 15);
        return e;
    endfunction

    function automatic exp_t obs1();
        return '{a: if1.A, en: if1.EN, busy: if1.busy, ld: if1.line_done, fd: if1.frame_done};
    endfunction

    function automatic exp_t obs2();
        return '{a: if2.A, en: if2.EN, busy: if2.busy, ld: if2.line_done, fd: if2.frame_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, int c, exp_t observed, exp_t expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, observed, expected);
        end
    endtask

    task automatic checkCount(string tag, int observed, int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        exp_t e;
        total = 0;
        bad   = 0;

        rst_n          = 1'b0;
        if1.start      = 1'b1;
        if1.continuous = 1'b0;
        if1.stop       = 1'b0;
        if2.start      = 1'b0;
        if2.continuous = 1'b0;
        if2.stop       = 1'b0;

        // Reset held with start high: nothing may start.
        tick();
        tick();
        checkOutput("reset", 0, obs1(), '0);
        checkOutput("reset2", 0, obs2(), '0);
        rst_n     = 1'b1;
        if1.start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("post_reset_idle", 0, obs1(), '0);

        // Single frame.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        ld_cnt = 0; fd_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 150; c++) begin
            checkOutput("single", c, obs1(), model_frame(c, 1'b0));
            ld_cnt   += int'(if1.line_done);
            fd_cnt   += int'(if1.frame_done);
            busy_cnt += int'(if1.busy);
            tick();
        end
        checkCount("single_line_done", ld_cnt, 16);
        checkCount("single_frame_done", fd_cnt, 1);
        checkCount("single_busy_cycles", busy_cnt, 143);

        // Continuous scanning with wrap; frame_done at 143 and 287.
        if1.start      = 1'b1;
        if1.continuous = 1'b1;
        tick();
        if1.start      = 1'b0;
        if1.continuous = 1'b0;
        fd_cnt = 0;
        for (int c = 1; c <= 300; c++) begin
            checkOutput("cont", c, obs1(), model_frame(c, 1'b1));
            if (if1.frame_done) begin
                fd_cnt++;
                checkCount("cont_fd_cycle", c, (fd_cnt == 1) ? 143 : 287);
            end
            tick();
        end
        checkCount("cont_frame_done", fd_cnt, 2);
        if1.stop = 1'b1;
        tick();
        if1.stop = 1'b0;
        waited = 0;
        while (if1.busy && waited < 40) begin
            tick();
            waited++;
        end
        checkCount("cont_stop_busy", int'(if1.busy), 0);

        // Stop on the 3rd dwell cycle of line 5 (cycle 48); line 5 ends at cycle 53.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        ld_cnt = 0; fd_cnt = 0;
        for (int c = 1; c <= 70; c++) begin
            e = (c <= 53) ? model_frame(c, 1'b0) : exp_t'('0);
            checkOutput("stop", c, obs1(), e);
            ld_cnt  += int'(if1.line_done);
            fd_cnt  += int'(if1.frame_done);
            if1.stop = (c == 48);
            tick();
        end
        if1.stop = 1'b0;
        checkCount("stop_line_done", ld_cnt, 6);
        checkCount("stop_frame_done", fd_cnt, 0);

        // start while busy (mid-frame, final line_done) ignored; first IDLE cycle accepted.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            if (c <= 143)      e = model_frame(c, 1'b0);
            else if (c == 144) e = '0;
            else               e = model_frame(c - 144, 1'b0);
            checkOutput("restart", c, obs1(), e);
            if1.start = (c == 20 || c == 143 || c == 144);
            tick();
        end
        if1.start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("reset_mid", 0, obs1(), '0);

        // Reset during line 7 (cycles 64..71), asserted in cycle 66.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            checkOutput("line7", c, obs1(), model_frame(c, 1'b0));
            rst_n = (c != 66);
            tick();
        end
        checkOutput("line7_reset", 67, obs1(), '0);
        rst_n = 1'b1;
        tick();
        checkOutput("line7_idle", 68, obs1(), '0);
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        checkOutput("line7_restart", 1, obs1(), model_frame(1, 1'b0));

        // DWELL=1, GAP=0: one line per cycle, EN high for 16 consecutive cycles.
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            e = '0;
            if (c <= 16) begin
                e.a    = 4'(c - 1);
                e.en   = 1'b1;
                e.busy = 1'b1;
                e.ld   = 1'b1;
                e.fd   = (c == 16);
            end
            checkOutput("fast", c, obs2(), e);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
